// File: rtl/sram_bus_ctrl_if.sv
// Bus bundle for the page-3 async-SRAM controller.
// CPU-side request/response plus the registered SRAM pin group.
interface sram_bus_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          busy;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    modport master (
        output req, we, addr, wdata, sram_dq_i,
        input  rdata, ready, busy, sram_addr, sram_dq_o,
        input  sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  req, we, addr, wdata, sram_dq_i,
        output rdata, ready, busy, sram_addr, sram_dq_o,
        output sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Async-SRAM controller: registered ce_n/oe_n/we_n sequencing with
// programmable read/write wait states and post-write turnaround.
module sram_bus_ctrl #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2,
    parameter int TURN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    sram_bus_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_TURN
    } state_t;

    localparam logic [3:0] RD_LOAD   = 4'(WAIT_RD - 1);
    localparam logic [3:0] WR_LOAD   = 4'(WAIT_WR - 1);
    localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          dq_oe_q, dq_oe_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dq_o_q, dq_o_d;

    // Next-state and next-pin values; every pin is taken from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        dq_oe_d = dq_oe_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dq_o_d  = dq_o_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d = bus.addr;
                    dq_o_d = bus.wdata;
                    ce_n_d = 1'b0;
                    if (bus.we) begin
                        state_d = S_WR_SETUP;
                        dq_oe_d = 1'b1;
                        we_n_d  = 1'b1;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = S_RD;
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = bus.sram_dq_i;
                    ready_d = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_SETUP: begin
                we_n_d  = 1'b0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    we_n_d  = 1'b1;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_HOLD: begin
                ready_d = 1'b1;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                if (TURN == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and pin registers; reset returns everything to the parked state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_o_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_dq_o  = dq_o_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = ce_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_we_n  = we_n_q;

endmodule
